uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter: serialises a WIDTH-bit parallel word onto the tx line as an 8N1-style frame.
//   Frame order: start bit (0), data LSB first, optional parity bit, one stop bit (1).
//   Companion to the UART receiver; the same BAUD_DIV setting (100 MHz / 9600 baud) gives a matched link.
//   Sits between the host/control logic (tx_start/data handshake) and the serial pin.
// PARAMETERS
//   WIDTH     8      data bits per frame
//   BAUD_DIV  10417  clock cycles per bit period (100 MHz / 9600 baud); must be >= 2
// PORTS
//   clk         in   1      system clock; all logic on posedge
//   reset       in   1      synchronous, active-low reset
//   tx_start    in   1      request to send; sampled only in IDLE
//   data        in   WIDTH  word to send; captured on the accepted tx_start cycle
//   tx          out  1      serial line; idles high
//   busy        out  1      high from the cycle after acceptance until frame end
//   done        out  1      one-cycle pulse at frame completion
// BEHAVIOUR
//   - Reset (reset==0 at posedge): tx=1, busy=0, done=0, state=IDLE, baud/bit counters=0, shift reg=0.
//     Applies mid-frame too: the frame is abandoned and the line returns high on the same edge.
//   - FSM states (encoded 3 bits): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, DONE=5.
//   - IDLE: tx=1, busy=0. If tx_start==1: latch data into the PISO, go to START.
//     Acceptance takes one cycle: tx goes 0 and busy 1 on the following posedge.
//   - Baud counter counts 0..BAUD_DIV-1 in every non-IDLE bit state; wrap = end of the bit period.
//     It clears on every state change, so each bit lasts exactly BAUD_DIV cycles.
//   - START: tx=0 for one bit period, then DATA.
//   - DATA: tx=shift_reg[0]; shift right at each wrap; the bit counter counts 0..WIDTH-1.
//     After the WIDTH-th wrap go to PARITY (if enabled) or STOP.
//   - PARITY: tx=parity bit for one bit period, then STOP.
//   - STOP: tx=1 for one bit period, then DONE.
//   - DONE: lasts one cycle. done=1, busy=0, tx=1, then IDLE.
//     A back-to-back tx_start is accepted in the IDLE cycle that follows.
//   - tx_start while busy (any non-IDLE state) is ignored. Changes on data after acceptance have no effect.
//   - Frame length (first tx=0 cycle to done pulse): (WIDTH+2)*BAUD_DIV cycles, +BAUD_DIV with parity.
//   - tx is driven from a register (glitch-free, no combinational path to the pin).
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     PARITY state active; the parity bit is even parity (XOR of the latched data word).
//   UART_TX_PARITY_EN undefined:
//     PARITY state and its logic compiled out; DATA goes straight to STOP.
// STRUCTURE
//   Package uart_pkg:
//     state encoding constants (shared with the receiver FSM)
//     default WIDTH and BAUD_DIV
//     TX_IDLE_LEVEL=1'b1
//   Sub-module piso_shift_register (mirror of the receiver's SIPO):
//     ports: load, shift, din[WIDTH-1:0], sout, bit_count, word_done.
//   The top level holds the FSM, the baud counter and the tx register.
// TESTING (sim with BAUD_DIV=16 unless stated)
//   1. Reset held low 10 cycles, tx_start=1 -> tx=1, busy=0, done=0 throughout; no frame.
//   2. Send 8'hAA -> tx = 0,0,1,0,1,0,1,0,1,1, 16 cycles each.
//      done pulses once, 160 cycles after tx first falls; busy high for 160 cycles.
//   3. Send 8'h00 then 8'hFF back-to-back, tx_start held high -> two frames with exactly 1 idle cycle between them.
//      Line shows 0x00 then 0xFF.
//   4. tx_start pulsed mid-frame with data=8'h55 while sending 8'h3C -> only 0x3C transmitted.
//      No second frame starts.
//   5. reset driven low during data bit 4 -> tx=1, busy=0 on that edge.
//      A new 8'hA5 sent afterwards is transmitted correctly.
//   6. UART_TX_PARITY_EN, send 8'h07 -> parity bit=1, frame 176 cycles.
//      Loopback into the UART receiver at BAUD_DIV=10417: 8'hAA received with data_valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX), default sizing, line idle level.
package uart_pkg;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam int   DEFAULT_BAUD_DIV = 10417;
  localparam logic TX_IDLE_LEVEL    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  // Even parity over a word zero-extended to 64 bits.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register, LSB first, with a bit counter (mirror of the receiver SIPO).
module piso_shift_register
  import uart_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BCW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic [BCW-1:0]   bit_count,
  output logic             word_done
);

  logic [WIDTH-1:0] shift_r;
  logic [BCW-1:0]   bit_count_r;
  logic             last_bit_s;

  assign last_bit_s = (bit_count_r == BCW'(WIDTH - 1));
  assign bit_count  = bit_count_r;
  assign word_done  = shift & last_bit_s;

  // Shift register and bit counter: load clears the count, each shift advances it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_r     <= '0;
      bit_count_r <= '0;
    end else if (load) begin
      shift_r     <= din;
      bit_count_r <= '0;
    end else if (shift) begin
      shift_r     <= {1'b0, shift_r[WIDTH-1:1]};
      bit_count_r <= last_bit_s ? '0 : bit_count_r + BCW'(1);
    end else begin
      shift_r     <= shift_r;
      bit_count_r <= bit_count_r;
    end
  end

  // sout looks ahead: it is the bit at the head after this cycle's load/shift,
  // so the top can register it onto the line on the same edge.
  always_comb begin
    sout = shift_r[0];
    if (load) begin
      sout = din[0];
    end else if (shift) begin
      sout = shift_r[1];
    end else begin
      sout = shift_r[0];
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional even parity, one stop bit.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_start,
  input  logic [WIDTH-1:0] data,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BDW = $clog2(BAUD_DIV);
  localparam int BCW = $clog2(WIDTH);

  uart_state_e    state_r;
  uart_state_e    state_s;
  logic [BDW-1:0] baud_cnt_r;
  logic           baud_wrap_s;
  logic           load_s;
  logic           shift_s;
  logic           sout_s;
  logic [BCW-1:0] bit_count_s;
  logic           word_done_s;
  logic           data_last_s;
  logic           tx_s;
  logic           busy_s;
  logic           done_s;
  logic           tx_r;
  logic           busy_r;
  logic           done_r;
`ifdef UART_TX_PARITY_EN
  logic           parity_r;
`endif

  assign baud_wrap_s = (baud_cnt_r == BDW'(BAUD_DIV - 1));
  assign load_s      = (state_r == ST_IDLE) && tx_start;
  assign shift_s     = (state_r == ST_DATA) && baud_wrap_s;
  assign data_last_s = word_done_s && (bit_count_s == BCW'(WIDTH - 1));

  piso_shift_register #(
    .WIDTH(WIDTH),
    .BCW  (BCW)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .shift    (shift_s),
    .din      (data),
    .sout     (sout_s),
    .bit_count(bit_count_s),
    .word_done(word_done_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (tx_start) state_s = ST_START; else state_s = ST_IDLE;
      ST_START:  if (baud_wrap_s) state_s = ST_DATA; else state_s = ST_START;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (data_last_s) state_s = ST_PARITY; else state_s = ST_DATA;
      ST_PARITY: if (baud_wrap_s) state_s = ST_STOP; else state_s = ST_PARITY;
`else
      ST_DATA:   if (data_last_s) state_s = ST_STOP; else state_s = ST_DATA;
`endif
      ST_STOP:   if (baud_wrap_s) state_s = ST_DONE; else state_s = ST_STOP;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered; registered below so the pin has no comb path.
  always_comb begin
    tx_s   = TX_IDLE_LEVEL;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_IDLE:   tx_s = TX_IDLE_LEVEL;
      ST_START:  begin tx_s = 1'b0;   busy_s = 1'b1; end
      ST_DATA:   begin tx_s = sout_s; busy_s = 1'b1; end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin tx_s = parity_r; busy_s = 1'b1; end
`endif
      ST_STOP:   begin tx_s = 1'b1;   busy_s = 1'b1; end
      ST_DONE:   done_s = 1'b1;
      default:   tx_s = TX_IDLE_LEVEL;
    endcase
  end

  // Baud counter: restarts on every state change so each bit lasts exactly BAUD_DIV cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_cnt_r <= '0;
    end else if ((state_s != state_r) || (state_r == ST_IDLE)) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + BDW'(1);
    end
  end

  // Registered line and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_r   <= TX_IDLE_LEVEL;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted word, captured alongside the PISO load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_r <= 1'b0;
    end else if (load_s) begin
      parity_r <= even_parity(64'(data));
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at BAUD_DIV=16; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_tx #(.WIDTH(8), .BAUD_DIV(BD)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .data    (data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Waits for the start bit, then checks every cycle of the frame, the done pulse and busy.
  // poke >= 0 drives tx_start with data 8'h55 for one cycle at that frame offset.
  task automatic check_frame(input logic [7:0] d, input int poke, input string name);
    logic [10:0] exp_bits;
    int nbits;
    int waited;
    int bad;
    int busy_bad;
    int done_bad;
    int idx;
    exp_bits = 11'd0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9]  = ^d;
    exp_bits[10] = 1'b1;
    nbits = 11;
`else
    exp_bits[9] = 1'b1;
    nbits = 10;
`endif
    waited = 0;
    while (tx !== 1'b0 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx !== 1'b0) begin
      $display("FAIL %s start: tx=%b after %0d cycles, required 0", name, tx, waited);
      return;
    end else passed++;
    busy_bad = 0;
    done_bad = 0;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = 0; c < BD; c++) begin
        idx = b * BD + c;
        if (poke >= 0 && idx == poke) begin
          tx_start = 1'b1;
          data     = 8'h55;
        end else if (poke >= 0 && idx == poke + 1) begin
          tx_start = 1'b0;
          data     = d;
        end
        if (tx !== exp_bits[b]) bad++;
        if (busy !== 1'b1) busy_bad++;
        if (done !== 1'b0) done_bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0)
        $display("FAIL %s bit%0d: %0d cycles wrong, required tx=%b for %0d cycles", name, b, bad, exp_bits[b], BD);
      else passed++;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL %s end: done=%b busy=%b tx=%b at cycle %0d, required 1 0 1", name, done, busy, tx, nbits * BD);
    else passed++;
    checks++;
    if (busy_bad != 0) $display("FAIL %s busy: low for %0d frame cycles, required 0", name, busy_bad);
    else passed++;
    checks++;
    if (done_bad != 0) $display("FAIL %s done_early: high for %0d frame cycles, required 0", name, done_bad);
    else passed++;
  endtask

  task automatic test_reset();
    int bad;
    reset    = 1'b0;
    tx_start = 1'b1;
    data     = 8'hAA;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_hold: %0d cycles with tx/busy/done != 1/0/0, required 0", bad);
    else passed++;
    tx_start = 1'b0;
    reset    = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_no_frame: %0d active cycles after release, required 0", bad);
    else passed++;
  endtask

  task automatic test_single();
    data     = 8'hAA;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    data     = 8'h00;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL accept_latency: tx=%b busy=%b, required 0 1", tx, busy);
    else passed++;
    check_frame(8'hAA, -1, "single_aa");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int bad;
    data     = 8'h00;
    tx_start = 1'b1;
    check_frame(8'h00, -1, "b2b_first");
    data = 8'hFF;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_gap: tx=%b busy=%b done=%b in idle cycle, required 1 0 0", tx, busy, done);
    else passed++;
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_restart: tx=%b busy=%b, required 0 1", tx, busy);
    else passed++;
    check_frame(8'hFF, -1, "b2b_second");
    tx_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL b2b_stop: %0d active cycles after release, required 0", bad);
    else passed++;
  endtask

  task automatic test_ignore_busy();
    int bad;
    data     = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame(8'h3C, 50, "ignore_3c");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL ignore_no_second: %0d active cycles, required 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int bad;
    data     = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (85) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL mid_pre: tx=%b busy=%b in data bit 4, required 0 1", tx, busy);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL mid_abandon: %0d active cycles after reset, required 0", bad);
    else passed++;
    data     = 8'hA5;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame(8'hA5, -1, "after_reset_a5");
  endtask

  task automatic test_odd_weight();
    data     = 8'h07;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame(8'h07, -1, "odd_07");
  endtask

  initial begin
    test_reset();
    test_single();
    @(negedge clk);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    @(negedge clk);
    test_odd_weight();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
